// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, opcode width and FSM state type for alu_seq.
package alu_seq_pkg;

  localparam int unsigned AC_N = 3;

  localparam int unsigned AC_AD = 0;
  localparam int unsigned AC_SB = 1;
  localparam int unsigned AC_AN = 2;
  localparam int unsigned AC_OR = 3;
  localparam int unsigned AC_LS = 4;
  localparam int unsigned AC_MU = 5;
  localparam int unsigned AC_DV = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between a requester (master) and alu_seq (slave).
interface alu_seq_if #(
  parameter int unsigned N    = 8,
  parameter int unsigned AC_N = 3
);
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    data_a;
  logic [N-1:0]    data_b;
  logic            carry_in;
  logic [AC_N-1:0] CS;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    S;
  logic [N-1:0]    S_hi;
  logic            zero;
  logic            carry_out;
  logic            err;

  modport master (
    output in_valid, data_a, data_b, carry_in, CS, out_ready,
    input  in_ready, out_valid, S, S_hi, zero, carry_out, err
  );

  modport slave (
    input  in_valid, data_a, data_b, carry_in, CS, out_ready,
    output in_ready, out_valid, S, S_hi, zero, carry_out, err
  );
endinterface

// File: rtl/alu_seq_iter.sv
// Shared shift datapath: one shift-add multiply or restoring-divide step per cycle.
// Divider step is present only when ALU_SEQ_DIV_EN is defined.
// acc holds product-high / remainder, lo holds multiplier->product-low / dividend->quotient.
module alu_seq_iter #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
`ifdef ALU_SEQ_DIV_EN
  input  logic         div_sel,
`endif
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] acc_nxt_c,
  output logic [N-1:0] lo_nxt_c
);
  localparam int unsigned W1 = N + 1;

  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [N-1:0]  b_q, b_d;
  logic [W1-1:0] mul_sum;
`ifdef ALU_SEQ_DIV_EN
  logic [W1-1:0] div_shift;
  logic          div_ge;
`endif

  // Next-state of the iteration registers: load operands or advance one step
  always_comb begin
    acc_d   = acc_q;
    lo_d    = lo_q;
    b_d     = b_q;
    mul_sum = W1'(acc_q) + (lo_q[0] ? W1'(b_q) : W1'(0));
`ifdef ALU_SEQ_DIV_EN
    div_shift = {acc_q, lo_q[N-1]};
    div_ge    = (div_shift >= W1'(b_q));
`endif
    if (load) begin
      acc_d = '0;
      lo_d  = a;
      b_d   = b;
    end else if (step) begin
`ifdef ALU_SEQ_DIV_EN
      if (div_sel) begin
        acc_d = div_ge ? N'(div_shift - W1'(b_q)) : div_shift[N-1:0];
        lo_d  = {lo_q[N-2:0], div_ge};
      end else
`endif
      begin
        acc_d = mul_sum[N:1];
        lo_d  = {mul_sum[0], lo_q[N-1:1]};
      end
    end
  end

  // Iteration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      lo_q  <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
    end
  end

  // Final step result is taken straight from next-state so DONE lands on the Nth step
  assign acc_nxt_c = acc_d;
  assign lo_nxt_c  = lo_d;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle AD/SB/AN/OR/LS, N-cycle MU and (optional) DV.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise opcode 6 is illegal.
module alu_seq #(
  parameter int unsigned N    = 8,
  parameter int unsigned AC_N = alu_seq_pkg::AC_N
) (
  input logic        clk,
  input logic        rst_n,
  alu_seq_if.slave   bus
);
  import alu_seq_pkg::*;

  localparam int unsigned W1    = N + 1;
  localparam int unsigned CNT_W = $clog2(N);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_pend_q, err_pend_d;
  logic [N-1:0]     s_q, s_d;
  logic [N-1:0]     s_hi_q, s_hi_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
`ifdef ALU_SEQ_DIV_EN
  logic             op_div_q, op_div_d;
`endif

  logic          accept_c, is_mu_c, is_dv_c, is_multi_c;
  logic [W1-1:0] sum_c, dif_c;
  logic [N-1:0]  res_s_c;
  logic          res_c_c, res_e_c;
  logic [N-1:0]  acc_nxt_c, lo_nxt_c;

  assign bus.in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept_c     = bus.in_valid && bus.in_ready;
  assign is_mu_c      = (bus.CS == AC_N'(AC_MU));
`ifdef ALU_SEQ_DIV_EN
  assign is_dv_c      = (bus.CS == AC_N'(AC_DV));
`else
  assign is_dv_c      = 1'b0;
`endif
  assign is_multi_c   = is_mu_c || is_dv_c;

  // Single-cycle opcode results; anything not handled here is illegal
  always_comb begin
    sum_c   = W1'(bus.data_a) + W1'(bus.data_b) + W1'(bus.carry_in);
    dif_c   = W1'(bus.data_a) - W1'(bus.data_b) - W1'(bus.carry_in);
    res_s_c = '0;
    res_c_c = 1'b0;
    res_e_c = 1'b0;
    case (bus.CS)
      AC_N'(AC_AD): {res_c_c, res_s_c} = sum_c;
      AC_N'(AC_SB): {res_c_c, res_s_c} = dif_c;
      AC_N'(AC_AN): res_s_c = bus.data_a & bus.data_b;
      AC_N'(AC_OR): res_s_c = bus.data_a | bus.data_b;
      AC_N'(AC_LS): res_s_c = N'(bus.data_a < bus.data_b);
      default:      res_e_c = 1'b1;
    endcase
  end

  alu_seq_iter #(.N(N)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept_c && is_multi_c),
    .step      (state_q == BUSY),
`ifdef ALU_SEQ_DIV_EN
    .div_sel   (op_div_q),
`endif
    .a         (bus.data_a),
    .b         (bus.data_b),
    .acc_nxt_c (acc_nxt_c),
    .lo_nxt_c  (lo_nxt_c)
  );

  // Next-state and result-register logic; a new accept overrides the plain transition
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_pend_d = err_pend_q;
    s_d        = s_q;
    s_hi_d     = s_hi_q;
    carry_d    = carry_q;
    err_d      = err_q;
`ifdef ALU_SEQ_DIV_EN
    op_div_d   = op_div_q;
`endif
    case (state_q)
      BUSY: begin
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = DONE;
          s_d     = lo_nxt_c;
          s_hi_d  = acc_nxt_c;
          carry_d = 1'b0;
          err_d   = err_pend_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: ;
    endcase
    if (accept_c) begin
      if (is_multi_c) begin
        state_d    = BUSY;
        cnt_d      = '0;
        err_pend_d = is_dv_c && (bus.data_b == '0);
`ifdef ALU_SEQ_DIV_EN
        op_div_d   = is_dv_c;
`endif
      end else begin
        state_d = DONE;
        s_d     = res_s_c;
        s_hi_d  = '0;
        carry_d = res_c_c;
        err_d   = res_e_c;
      end
    end
    zero_d      = (s_d == '0);
    out_valid_d = (state_d == DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_pend_q  <= 1'b0;
      s_q         <= '0;
      s_hi_q      <= '0;
      zero_q      <= 1'b1;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      op_div_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_pend_q  <= err_pend_d;
      s_q         <= s_d;
      s_hi_q      <= s_hi_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_SEQ_DIV_EN
      op_div_q    <= op_div_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.S         = s_q;
  assign bus.S_hi      = s_hi_q;
  assign bus.zero      = zero_q;
  assign bus.carry_out = carry_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed table-driven bench for alu_seq (N=8); DV expectations follow ALU_SEQ_DIV_EN.
module tb_alu_seq;
  localparam int unsigned N       = 8;
  localparam int          LAT_MAX = 40;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_seq_if #(.N(N), .AC_N(3)) bus ();

  alu_seq #(.N(N), .AC_N(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [2:0] cs;
    logic [7:0] s;
    logic [7:0] s_hi;
    logic       z;
    logic       c;
    logic       e;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [2:0] cs, input logic [7:0] s,
                         input logic [7:0] s_hi, input logic z, input logic c,
                         input logic e, input int lat);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.cin = cin; v.cs = cs;
    v.s = s; v.s_hi = s_hi; v.z = z; v.c = c; v.e = e; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Present a request, wait for acceptance, then scramble the inputs
  task automatic start_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [2:0] cs);
    int n = 0;
    bus.data_a   = a;
    bus.data_b   = b;
    bus.carry_in = cin;
    bus.CS       = cs;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < LAT_MAX) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= LAT_MAX) check({name, " accept_timeout"}, 32'(n), 32'(0));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.data_a   = 8'($urandom);
    bus.data_b   = 8'($urandom);
    bus.carry_in = 1'($urandom);
    bus.CS       = 3'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < LAT_MAX) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] or_a [5];
    logic [7:0] or_b [5];
    logic [7:0] or_s [5];

    add_vec("ad_ff_01_c1", 8'hFF, 8'h01, 1'b1, 3'd0, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1);
    add_vec("ad_12_34",    8'h12, 8'h34, 1'b0, 3'd0, 8'h46, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    add_vec("ad_ff_00_c1", 8'hFF, 8'h00, 1'b1, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1);
    add_vec("sb_05_05",    8'h05, 8'h05, 1'b0, 3'd1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1);
    add_vec("sb_00_01",    8'h00, 8'h01, 1'b0, 3'd1, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1);
    add_vec("sb_10_01_c1", 8'h10, 8'h01, 1'b1, 3'd1, 8'h0E, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    add_vec("an_f0_3c",    8'hF0, 8'h3C, 1'b0, 3'd2, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    add_vec("or_f0_0f",    8'hF0, 8'h0F, 1'b1, 3'd3, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    add_vec("or_00_00",    8'h00, 8'h00, 1'b0, 3'd3, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1);
    add_vec("ls_03_07",    8'h03, 8'h07, 1'b0, 3'd4, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    add_vec("ls_07_03",    8'h07, 8'h03, 1'b0, 3'd4, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1);
    add_vec("ls_ff_ff",    8'hFF, 8'hFF, 1'b1, 3'd4, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1);
    add_vec("mu_ff_ff",    8'hFF, 8'hFF, 1'b0, 3'd5, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 9);
    add_vec("mu_0c_0d",    8'h0C, 8'h0D, 1'b1, 3'd5, 8'h9C, 8'h00, 1'b0, 1'b0, 1'b0, 9);
    add_vec("mu_10_10",    8'h10, 8'h10, 1'b0, 3'd5, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 9);
    add_vec("illegal_7",   8'h12, 8'h34, 1'b1, 3'd7, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1);
`ifdef ALU_SEQ_DIV_EN
    add_vec("dv_64_07",    8'h64, 8'h07, 1'b0, 3'd6, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b0, 9);
    add_vec("dv_55_00",    8'h55, 8'h00, 1'b0, 3'd6, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b1, 9);
    add_vec("dv_07_09",    8'h07, 8'h09, 1'b0, 3'd6, 8'h00, 8'h07, 1'b1, 1'b0, 1'b0, 9);
`else
    add_vec("dv_64_07",    8'h64, 8'h07, 1'b0, 3'd6, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1);
    add_vec("dv_55_00",    8'h55, 8'h00, 1'b0, 3'd6, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1);
`endif

    or_a[0] = 8'h01; or_b[0] = 8'h10; or_s[0] = 8'h11;
    or_a[1] = 8'h02; or_b[1] = 8'h20; or_s[1] = 8'h22;
    or_a[2] = 8'h40; or_b[2] = 8'h04; or_s[2] = 8'h44;
    or_a[3] = 8'h00; or_b[3] = 8'h00; or_s[3] = 8'h00;
    or_a[4] = 8'hF0; or_b[4] = 8'h0F; or_s[4] = 8'hFF;

    // Reset state
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.data_a    = '0;
    bus.data_b    = '0;
    bus.carry_in  = 1'b0;
    bus.CS        = '0;
    #23;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst out_valid", 32'(bus.out_valid), 32'(0));
    check("rst in_ready",  32'(bus.in_ready),  32'(1));
    check("rst S",         32'(bus.S),         32'(0));
    check("rst S_hi",      32'(bus.S_hi),      32'(0));
    check("rst zero",      32'(bus.zero),      32'(1));
    check("rst carry_out", 32'(bus.carry_out), 32'(0));
    check("rst err",       32'(bus.err),       32'(0));

    // Table of single operations
    for (int i = 0; i < vecs.size(); i++) begin
      start_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].cs);
      wait_valid(lat);
      check({vecs[i].name, " latency"},   32'(lat),           32'(vecs[i].lat));
      check({vecs[i].name, " out_valid"}, 32'(bus.out_valid), 32'(1));
      check({vecs[i].name, " S"},         32'(bus.S),         32'(vecs[i].s));
      check({vecs[i].name, " S_hi"},      32'(bus.S_hi),      32'(vecs[i].s_hi));
      check({vecs[i].name, " zero"},      32'(bus.zero),      32'(vecs[i].z));
      check({vecs[i].name, " carry_out"}, 32'(bus.carry_out), 32'(vecs[i].c));
      check({vecs[i].name, " err"},       32'(bus.err),       32'(vecs[i].e));
      release_out();
    end

    // MU result held stable while out_ready stays low
    start_op("mu_hold", 8'hFF, 8'hFF, 1'b0, 3'd5);
    wait_valid(lat);
    check("mu_hold latency", 32'(lat), 32'(9));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("mu_hold out_valid", 32'(bus.out_valid), 32'(1));
      check("mu_hold S",         32'(bus.S),         32'(8'h01));
      check("mu_hold S_hi",      32'(bus.S_hi),      32'(8'hFE));
      check("mu_hold in_ready",  32'(bus.in_ready),  32'(0));
    end
    release_out();
    check("mu_hold drained", 32'(bus.out_valid), 32'(0));

    // Reset pulse in the fourth BUSY cycle aborts the multiply
    start_op("mu_abort", 8'h0B, 8'h0D, 1'b0, 3'd5);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort in_ready during rst",  32'(bus.in_ready),  32'(1));
    check("abort out_valid during rst", 32'(bus.out_valid), 32'(0));
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort in_ready",  32'(bus.in_ready),  32'(1));
    check("abort out_valid", 32'(bus.out_valid), 32'(0));
    repeat (N + 3) @(posedge clk);
    #1;
    check("abort no late result", 32'(bus.out_valid), 32'(0));
    start_op("an_after_abort", 8'hF0, 8'h3C, 1'b0, 3'd2);
    wait_valid(lat);
    check("an_after_abort latency", 32'(lat),   32'(1));
    check("an_after_abort S",       32'(bus.S), 32'(8'h30));
    release_out();

    // Back-to-back OR stream with out_ready held high
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.data_a   = or_a[i];
      bus.data_b   = or_b[i];
      bus.carry_in = 1'b0;
      bus.CS       = 3'd3;
      bus.in_valid = 1'b1;
      #1;
      check($sformatf("b2b in_ready %0d", i), 32'(bus.in_ready), 32'(1));
      @(posedge clk); #1;
      check($sformatf("b2b out_valid %0d", i), 32'(bus.out_valid), 32'(1));
      check($sformatf("b2b S %0d", i),         32'(bus.S),         32'(or_s[i]));
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b no duplicate", 32'(bus.out_valid), 32'(0));
    bus.out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
